// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
//
// Programmable pulse generator. After an accepted start it emits pulse_num
// high pulses on pulse_out. Each pulse is high_cnt cycles high followed by
// low_cnt cycles low. A pulse_num of 0 runs continuously until abort. This is
// the transmit-side partner of the pulse width counter: a pulse of N cycles
// measured there reads back as width_count = N-1.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous reset, active-low
//   start      in   one-cycle request, only looked at while idle
//   abort      in   terminate the train in progress
//   high_cnt   in   high-phase length in cycles (CW bits), latched on start
//   low_cnt    in   low-phase length in cycles (CW bits), latched on start
//   pulse_num  in   number of pulses (NW bits), 0 = continuous
//   pulse_out  out  generated waveform (registered)
//   busy       out  train in progress
//   done       out  one-cycle flag, train completed normally
//   aborted    out  one-cycle flag, train terminated by abort
//   cfg_err    out  one-cycle flag, start rejected because high_cnt was 0
//   pulse_cnt  out  high phases completed in the current/last train
// ---------------------------------------------------------------------------
module pulse_train_gen #(
    parameter int CW = 32,
    parameter int NW = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] high_cnt,
    input  logic [CW-1:0] low_cnt,
    input  logic [NW-1:0] pulse_num,
    output logic          pulse_out,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          cfg_err,
    output logic [NW-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] phase_cnt;
    logic [CW-1:0] phase_cnt_n;
    logic [CW-1:0] high_len;
    logic [CW-1:0] high_len_n;
    logic [CW-1:0] low_len;
    logic [CW-1:0] low_len_n;
    logic [NW-1:0] num_len;
    logic [NW-1:0] num_len_n;
    logic [NW-1:0] pulse_cnt_n;
    logic          done_n;
    logic          aborted_n;
    logic          cfg_err_n;

    // Next-state logic. The phase counter is loaded with the phase length
    // and counts down to 1; the cycle in which it reads 1 is the last cycle
    // of the phase, so a length of N gives exactly N cycles.
    always_comb begin
        state_n     = state;
        phase_cnt_n = phase_cnt;
        high_len_n  = high_len;
        low_len_n   = low_len;
        num_len_n   = num_len;
        pulse_cnt_n = pulse_cnt;
        done_n      = 1'b0;
        aborted_n   = 1'b0;
        cfg_err_n   = 1'b0;

        case (state)
            IDLE: begin
                // abort is meaningless here, so start always takes priority
                if (start) begin
                    if (high_cnt == '0) begin
                        cfg_err_n = 1'b1;
                    end else begin
                        high_len_n  = high_cnt;
                        // a zero low phase is stretched to one cycle so
                        // consecutive pulses always show a falling edge
                        low_len_n   = (low_cnt == '0) ? CW'(1) : low_cnt;
                        num_len_n   = pulse_num;
                        pulse_cnt_n = '0;
                        phase_cnt_n = high_cnt;
                        state_n     = HIGH;
                    end
                end
            end

            HIGH: begin
                if (abort) begin
                    aborted_n = 1'b1;
                    state_n   = IDLE;
                end else if (phase_cnt == CW'(1)) begin
                    pulse_cnt_n = pulse_cnt + NW'(1);
                    phase_cnt_n = low_len;
                    state_n     = LOW;
                end else begin
                    phase_cnt_n = phase_cnt - CW'(1);
                end
            end

            LOW: begin
                // abort beats completion even on the final low cycle
                if (abort) begin
                    aborted_n = 1'b1;
                    state_n   = IDLE;
                end else if (phase_cnt == CW'(1)) begin
                    if ((num_len != '0) && (pulse_cnt == num_len)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        phase_cnt_n = high_len;
                        state_n     = HIGH;
                    end
                end else begin
                    phase_cnt_n = phase_cnt - CW'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers. pulse_out and busy are derived from the
    // next state so they line up exactly with the state they describe.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            high_len  <= '0;
            low_len   <= '0;
            num_len   <= '0;
            pulse_cnt <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_n;
            phase_cnt <= phase_cnt_n;
            high_len  <= high_len_n;
            low_len   <= low_len_n;
            num_len   <= num_len_n;
            pulse_cnt <= pulse_cnt_n;
            pulse_out <= (state_n == HIGH);
            busy      <= (state_n != IDLE);
            done      <= done_n;
            aborted   <= aborted_n;
            cfg_err   <= cfg_err_n;
        end
    end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Programmable pulse generator: emits a train of `pulse_num` high pulses on `pulse_out`.
  - Each pulse is exactly `high_cnt` sys_clk cycles high, followed by `low_cnt` cycles low.
- Transmit-side counterpart of the team's pulse width counter. It is used for stimulus generation, loopback self-test and calibration of the width measurement path.
- Loopback contract: a pulse of N cycles fed to the width counter yields `width_count = N-1`.

Parameters:
- CW, 32, width of `high_cnt`, `low_cnt` and the internal phase counter.
- NW, 16, width of `pulse_num` and `pulse_cnt`.

Ports:
- sys_clk  input  1  system clock (100 MHz).
- sys_rst_n  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  terminate the train in progress.
- high_cnt  input  CW  high-phase length in cycles; latched on accepted start.
- low_cnt  input  CW  low-phase length in cycles; latched on accepted start.
- pulse_num  input  NW  number of pulses; 0 = continuous until abort.
- pulse_out  output  1  generated waveform (registered).
- busy  output  1  train in progress.
- done  output  1  one-cycle flag: train completed normally.
- aborted  output  1  one-cycle flag: train terminated by abort.
- cfg_err  output  1  one-cycle flag: start rejected (`high_cnt == 0`).
- pulse_cnt  output  NW  high phases completed in the current/last train.

Behaviour:
- Clock and reset: reset is sys_rst_n, asynchronous, active-low; clock is sys_clk.
- Reset values:
  - All outputs 0; state IDLE; internal counters 0.
  - Asserting reset mid-train forces `pulse_out` = 0 immediately (asynchronous).
- State machine: IDLE, HIGH, LOW.
- IDLE, on `start`:
  - If `high_cnt == 0`: assert `cfg_err` next cycle, remain IDLE, do not touch `pulse_cnt`.
  - Otherwise:
    - Latch `high_cnt`, `low_cnt` and `pulse_num`.
    - Clear `pulse_cnt`.
    - Go to HIGH.
  - Latency: `pulse_out` and `busy` rise in the cycle after `start` is sampled.
- Low-phase clamp: a latched `low_cnt == 0` is clamped to 1, so every pulse has a visible falling edge.
- HIGH:
  - `pulse_out` = 1 for exactly `high_cnt` cycles.
  - On the last cycle of the phase, increment `pulse_cnt` (wraps modulo 2^NW in continuous mode), then go to LOW.
- LOW:
  - `pulse_out` = 0 for exactly `low_cnt` cycles.
  - At phase end, one of:
    - `pulse_num != 0` and `pulse_cnt == pulse_num`: go to IDLE, `busy` falls, and `done` = 1 for the single cycle in which `busy` first reads 0.
    - Otherwise: go to HIGH.
  - The trailing low phase is always executed before `done`.
- `busy` = 1 in every HIGH and LOW cycle; 0 in IDLE.
- `start` while `busy` is ignored: no re-latch and no error.
- Input changes to `high_cnt`, `low_cnt` and `pulse_num` during a train have no effect.
- `abort` while `busy`:
  - Next cycle: `pulse_out` = 0, `busy` = 0, `aborted` = 1 for one cycle, state IDLE.
  - `done` is not asserted; `pulse_cnt` holds its value.
  - `abort` in IDLE has no effect.
- Simultaneous events:
  - `abort` and `start` in IDLE: start is accepted (abort ignored in IDLE).
  - `abort` on the final LOW cycle: abort wins, so `aborted` = 1 and `done` = 0.
- Counter arithmetic:
  - The phase counter is CW bits, loads the phase length and decrements to 1; no overflow.
  - `high_cnt` = 2^CW-1 is legal.
- `done`, `aborted` and `cfg_err` are mutually exclusive and never asserted for more than one cycle.

Test Plan:
- Single pulse: `high_cnt`=5, `low_cnt`=3, `pulse_num`=1, `start` at cycle 0.
  - `pulse_out` is high cycles 1–5 and low cycles 6–8; `busy` is high cycles 1–8; `done`=1 at cycle 9.
  - `pulse_cnt`=1; looped into the width counter, `valid` fires with `width_count`=4.
- Train: `high_cnt`=2, `low_cnt`=2, `pulse_num`=3.
  - `pulse_out` = 1100 1100 1100 from cycle 1, then `done` at cycle 13 with `pulse_cnt`=3.
- Config error and clamp:
  - `high_cnt`=0 → `cfg_err`=1 for one cycle, `busy` stays 0.
  - `low_cnt`=0, `high_cnt`=1, `pulse_num`=2 → `pulse_out` = 1010, then `done`.
- Continuous and abort: `high_cnt`=1, `low_cnt`=1, `pulse_num`=0; `abort` at cycle 10.
  - At cycle 11: `pulse_out`=0, `busy`=0, `aborted`=1, `done`=0; `pulse_cnt`=5 holds.
- Start while busy: second `start` with `high_cnt`=9 during a train → the waveform keeps its original `high_cnt` and the train completes unaffected.
- Reset mid-HIGH: `sys_rst_n` low → `pulse_out`, `busy` and `pulse_cnt` read 0 immediately; after release, a new `start` works normally.
